// File: rtl/mux_n_stream_if.sv
// N:1 stream selector bus: N_IN source channels in, one registered stream out.
// Latency: n/a (wiring only).
// Backpressure: carried by in_ready/out_ready.
interface mux_n_stream_if #(
    parameter int N_IN   = 3,
    parameter int DATA_W = 7
);
    localparam int SEL_W = $clog2(N_IN);

    logic [N_IN*DATA_W-1:0] in_data;
    logic [N_IN-1:0]        in_valid;
    logic [N_IN-1:0]        in_ready;
    logic                   mode;
    logic [SEL_W-1:0]       sel;
    logic [DATA_W-1:0]      out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [SEL_W-1:0]       out_src;
    logic                   sel_err;
    logic [15:0]            beat_cnt;

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_valid, out_src, sel_err, beat_cnt
    );

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_valid, out_src, sel_err, beat_cnt
    );
endinterface

// File: rtl/mux_n_stream.sv
// N:1 valid/ready stream selector, fixed or round-robin; MUX_BEAT_CNT_EN adds a beat counter.
// Latency: 1 cycle, full throughput.
// Backpressure: output register holds while out_valid && !out_ready; no input is granted then.
module mux_n_stream #(
    parameter int N_IN   = 3,
    parameter int DATA_W = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    mux_n_stream_if.slave bus
);
    localparam int SEL_W = $clog2(N_IN);

    logic [SEL_W-1:0]  r_rr_ptr;
    logic [SEL_W-1:0]  r_src;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_sel_err;

    logic [SEL_W-1:0]  w_gnt;
    logic              w_gnt_vld;
    logic [DATA_W-1:0] w_gnt_dat;
    logic [N_IN-1:0]   w_in_ready;
    logic              w_load;
    logic              w_xfer;
    logic              w_sel_oob;

    assign w_load    = !r_valid || bus.out_ready;
    assign w_sel_oob = (int'(bus.sel) >= N_IN);
    assign w_xfer    = w_gnt_vld && w_load;

    // Round-robin scans downward so the lowest offset from r_rr_ptr is assigned last and wins.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = '0;
        if (!bus.mode) begin
            for (int i = 0; i < N_IN; i++) begin
                if (int'(bus.sel) == i && bus.in_valid[i]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt     = SEL_W'(i);
                end
            end
        end else begin
            for (int k = N_IN - 1; k >= 0; k--) begin
                if (bus.in_valid[(int'(r_rr_ptr) + k) % N_IN]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt     = SEL_W'((int'(r_rr_ptr) + k) % N_IN);
                end
            end
        end
    end

    always_comb begin
        w_gnt_dat  = '0;
        w_in_ready = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (int'(w_gnt) == i) begin
                w_gnt_dat     = bus.in_data[i*DATA_W +: DATA_W];
                w_in_ready[i] = w_gnt_vld && w_load && rst_n;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_src     <= '0;
            r_rr_ptr  <= '0;
            r_sel_err <= 1'b0;
        end else begin
            if (w_load) begin
                r_valid <= w_xfer;
                if (w_xfer) begin
                    r_data <= w_gnt_dat;
                    r_src  <= w_gnt;
                end
            end
            if (w_xfer && bus.mode) begin
                r_rr_ptr <= (int'(w_gnt) == N_IN - 1) ? '0 : SEL_W'(int'(w_gnt) + 1);
            end
            if (!bus.mode && w_sel_oob) begin
                r_sel_err <= 1'b1;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_data  = r_data;
    assign bus.out_valid = r_valid;
    assign bus.out_src   = r_src;
    assign bus.sel_err   = r_sel_err;

`ifdef MUX_BEAT_CNT_EN
    logic [15:0] r_beat_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_cnt <= '0;
        end else if (r_valid && bus.out_ready && r_beat_cnt != 16'hFFFF) begin
            r_beat_cnt <= r_beat_cnt + 16'd1;
        end
    end

    assign bus.beat_cnt = r_beat_cnt;
`else
    assign bus.beat_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_mux_n_stream.sv
// Directed bench for mux_n_stream (N_IN=3, DATA_W=7): fixed, round-robin, backpressure,
// bad select, async reset and beat counter.
module tb_mux_n_stream;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    mux_n_stream_if #(.N_IN(3), .DATA_W(7)) bus ();

    mux_n_stream #(.N_IN(3), .DATA_W(7)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          s;
        logic [1:0]  src_q [5];
        logic [6:0]  dat_q [3];
        logic [1:0]  fsel  [4];
        total = 0;
        bad   = 0;
        dat_q = '{7'h00, 7'h01, 7'h7F};
        fsel  = '{2'd0, 2'd1, 2'd2, 2'd0};
        src_q = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};

        // Reset with all sources valid: nothing may be granted while rst_n is low.
        rst_n         = 1'b0;
        bus.in_data   = {7'h7F, 7'h01, 7'h00};
        bus.in_valid  = 3'b111;
        bus.mode      = 1'b0;
        bus.sel       = 2'd0;
        bus.out_ready = 1'b1;
        #2;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data",  32'(bus.out_data),  32'd0);
        chk("rst_out_src",   32'(bus.out_src),   32'd0);
        chk("rst_sel_err",   32'(bus.sel_err),   32'd0);
        chk("rst_beat_cnt",  32'(bus.beat_cnt),  32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
        #10;
        rst_n = 1'b1;
        #1;

        // Fixed select stepping 0,1,2,0.
        for (int i = 0; i < 4; i++) begin
            bus.sel = fsel[i];
            #1;
            chk("fix_in_ready", 32'(bus.in_ready), 32'(3'b001 << fsel[i]));
            tick();
            chk("fix_out_data",  32'(bus.out_data),  32'(dat_q[fsel[i]]));
            chk("fix_out_src",   32'(bus.out_src),   32'(fsel[i]));
            chk("fix_out_valid", 32'(bus.out_valid), 32'd1);
        end

        // Round-robin from rr_ptr=0 (untouched by fixed mode).
        bus.mode = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("rr_in_ready", 32'(bus.in_ready), 32'(3'b001 << src_q[i]));
            tick();
            chk("rr_out_src",  32'(bus.out_src),  32'(src_q[i]));
            chk("rr_out_data", 32'(bus.out_data), 32'(dat_q[src_q[i]]));
        end

        // Backpressure on a held ch1 beat; rr_ptr is now 2.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            tick();
            chk("bp_out_data",  32'(bus.out_data),  32'h01);
            chk("bp_out_src",   32'(bus.out_src),   32'd1);
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_rel_in_ready", 32'(bus.in_ready), 32'b100);
        tick();
        chk("bp_rel_out_src",   32'(bus.out_src),   32'd2);
        chk("bp_rel_out_data",  32'(bus.out_data),  32'h7F);
        chk("bp_rel_out_valid", 32'(bus.out_valid), 32'd1);

        // Out-of-range select: drains to empty and latches sel_err.
        bus.mode = 1'b0;
        bus.sel  = 2'd3;
        #1;
        chk("bad_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        chk("bad_out_valid", 32'(bus.out_valid), 32'd0);
        chk("bad_out_data",  32'(bus.out_data),  32'h7F);
        chk("bad_out_src",   32'(bus.out_src),   32'd2);
        chk("bad_sel_err",   32'(bus.sel_err),   32'd1);
        bus.sel = 2'd1;
        #1;
        chk("fix1_in_ready", 32'(bus.in_ready), 32'b010);
        tick();
        chk("fix1_out_data",   32'(bus.out_data),  32'h01);
        chk("fix1_out_valid",  32'(bus.out_valid), 32'd1);
        chk("sticky_sel_err",  32'(bus.sel_err),   32'd1);

        // Round-robin resumes at ch0 (rr_ptr held through fixed mode), then async reset mid-cycle.
        bus.mode = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rr2_out_src", 32'(bus.out_src), 32'(src_q[i]));
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_out_data",  32'(bus.out_data),  32'd0);
        chk("arst_out_src",   32'(bus.out_src),   32'd0);
        chk("arst_sel_err",   32'(bus.sel_err),   32'd0);
        chk("arst_in_ready",  32'(bus.in_ready),  32'd0);
        #1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'b001);

        // Five beats through, then drain.
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_rst_src", 32'(bus.out_src), 32'(src_q[i]));
        end
        bus.in_valid = 3'b000;
        tick();
        chk("drain_out_valid", 32'(bus.out_valid), 32'd0);
`ifdef MUX_BEAT_CNT_EN
        s = 5;
`else
        s = 0;
`endif
        chk("beat_cnt", 32'(bus.beat_cnt), 32'(s));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
